// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the CPU-to-SRAM/boot-ROM memory cycle controller.
package mem_ctrl_pkg;

    localparam int          WAIT_W   = 2;
    localparam logic [7:0]  CFG_PORT = 8'h70;
    localparam logic [19:0] ROM_TOP  = 20'h00200;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        ACCESS,
        RECOVER
    } state_t;

    // The boot ROM overlays the bottom of the address space until it is unmapped.
    function automatic logic addr_is_rom(input logic [19:0] addr, input logic rom_dis);
        return !rom_dis && (addr < ROM_TOP);
    endfunction

endpackage

// File: rtl/mem_cycle_ctrl_sync2.sv
// Two-flop synchronizer for one asynchronous CPU strobe; reset value is the strobe's idle level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic hwclk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Sequences CPU memory cycles onto an async SRAM or the FPGA boot ROM, with configurable wait states.
//
// state   | meaning
// IDLE    | waiting for a legal memory read/write request
// SETUP   | address/CE setup cycle, wait counter loaded
// WAIT    | inserting wait states, counter decrements
// ACCESS  | strobes active (WE only here), held until MREQ releases
// RECOVER | one cycle with every strobe inactive
module mem_cycle_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              hwclk,
    input  logic              reset_n,
    input  logic [19:0]       a,
    input  logic [7:0]        d_in,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              m1_n,
    input  logic              rfsh_n,
    output logic              ce_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              rom_sel,
    output logic              wait_n,
    output logic              rom_dis,
    output logic [WAIT_W-1:0] wait_cfg
);

    logic mreq_s, iorq_s, rd_s, wr_s, m1_s, rfsh_s;

    sync2 #(.RST_VAL(1'b1)) u_sync_mreq (.hwclk(hwclk), .reset_n(reset_n), .d(mreq_n), .q(mreq_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_iorq (.hwclk(hwclk), .reset_n(reset_n), .d(iorq_n), .q(iorq_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_rd   (.hwclk(hwclk), .reset_n(reset_n), .d(rd_n),   .q(rd_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_wr   (.hwclk(hwclk), .reset_n(reset_n), .d(wr_n),   .q(wr_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_m1   (.hwclk(hwclk), .reset_n(reset_n), .d(m1_n),   .q(m1_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_rfsh (.hwclk(hwclk), .reset_n(reset_n), .d(rfsh_n), .q(rfsh_s));

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic                is_rom_q, is_rom_d;
    logic                armed_q, armed_d;
    logic [1:0]          live_q, live_d;
    logic                iorq_prev_q, iorq_prev_d;
    logic                cfg_pend_q, cfg_pend_d;
    logic [7:0]          shadow_q, shadow_d;
    logic                rom_dis_q, rom_dis_d;
    logic [WAIT_W-1:0]   wait_cfg_q, wait_cfg_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                rom_sel_q, rom_sel_d;
    logic                wait_n_q, wait_n_d;
    logic                start;
    logic                active;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        is_rom_d    = is_rom_q;
        armed_d     = armed_q;
        live_d      = {live_q[0], 1'b1};
        iorq_prev_d = iorq_s;
        cfg_pend_d  = cfg_pend_q;
        shadow_d    = shadow_q;
        rom_dis_d   = rom_dis_q;
        wait_cfg_d  = wait_cfg_q;

        // live_q[1] marks when mreq_s reflects a real sample rather than the synchronizer reset value,
        // so an MREQ held low across reset never starts a cycle.
        start = armed_q && !mreq_s && iorq_s && rfsh_s && (rd_s ^ wr_s);
        if (start) begin
            armed_d = 1'b0;
        end else if (mreq_s && live_q[1]) begin
            armed_d = 1'b1;
        end

        if (!iorq_s && !wr_s && m1_s && (a[7:0] == CFG_PORT)) begin
            shadow_d   = d_in;
            cfg_pend_d = 1'b1;
        end
        if (iorq_s && !iorq_prev_q && cfg_pend_q) begin
            rom_dis_d  = shadow_q[0];
            wait_cfg_d = shadow_q[2:1];
            cfg_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETUP;
                    cnt_d    = wait_cfg_q;
                    is_wr_d  = !wr_s;
                    is_rom_d = addr_is_rom(a, rom_dis_q);
                end
            end
            SETUP: begin
                if (mreq_s)                 state_d = RECOVER;
                else if (cnt_q != '0)       state_d = WAIT;
                else                        state_d = ACCESS;
            end
            WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (mreq_s)                      state_d = RECOVER;
                else if (cnt_q == WAIT_W'(1))    state_d = ACCESS;
            end
            ACCESS: begin
                if (mreq_s) state_d = RECOVER;
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        active    = (state_d == SETUP) || (state_d == WAIT) || (state_d == ACCESS);
        ce_n_d    = !(active && !is_rom_d);
        oe_n_d    = !(active && !is_rom_d && !is_wr_d);
        we_n_d    = !((state_d == ACCESS) && !is_rom_d && is_wr_d);
        rom_sel_d = active && is_rom_d && !is_wr_d;
        wait_n_d  = !(((state_d == SETUP) && (cnt_d != '0)) || (state_d == WAIT));
    end

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            is_rom_q    <= 1'b0;
            armed_q     <= 1'b0;
            live_q      <= 2'b00;
            iorq_prev_q <= 1'b1;
            cfg_pend_q  <= 1'b0;
            shadow_q    <= 8'h00;
            rom_dis_q   <= 1'b0;
            wait_cfg_q  <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            rom_sel_q   <= 1'b0;
            wait_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            is_rom_q    <= is_rom_d;
            armed_q     <= armed_d;
            live_q      <= live_d;
            iorq_prev_q <= iorq_prev_d;
            cfg_pend_q  <= cfg_pend_d;
            shadow_q    <= shadow_d;
            rom_dis_q   <= rom_dis_d;
            wait_cfg_q  <= wait_cfg_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            rom_sel_q   <= rom_sel_d;
            wait_n_q    <= wait_n_d;
        end
    end

    // Upper shadow bits are latched from the bus but carry no configuration yet.
    logic unused_shadow;
    assign unused_shadow = ^shadow_q[7:3];

    assign ce_n     = ce_n_q;
    assign oe_n     = oe_n_q;
    assign we_n     = we_n_q;
    assign rom_sel  = rom_sel_q;
    assign wait_n   = wait_n_q;
    assign rom_dis  = rom_dis_q;
    assign wait_cfg = wait_cfg_q;

endmodule
